// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32 control path:
// FSM state encoding, supported opcodes, ALU operation selects and
// branch funct3 codes.
package core_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    ADDR_CALC,
    MEM_RD,
    MEM_WR,
    WB_R,
    WB_LD,
    BRANCH,
    TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_CMP   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Loads and stores share the address-calculation step.
  function automatic logic isMemOp(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Single memory request handshake shared by instruction fetch and
// data loads/stores. The controller is the master; memory answers
// with memReady in the cycle it completes the request.
interface multicycle_ctrl_if;

  logic memReq;
  logic memWe;
  logic memAddrSel;
  logic memReady;

  modport master (
    output memReq,
    output memWe,
    output memAddrSel,
    input  memReady
  );

  modport slave (
    input  memReq,
    input  memWe,
    input  memAddrSel,
    output memReady
  );

endinterface

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch resolution from funct3 and the ALU compare flags. funct3
// codes 010/011 are not branches and are reported as illegal.
module branch_cond
  import core_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_aluZero,
  input  logic       i_aluLt,
  input  logic       i_aluLtu,
  output logic       o_taken,
  output logic       o_illegal
);

  // Select the taken condition for the captured branch type.
  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = i_aluZero;
      F3_BNE:  o_taken = !i_aluZero;
      F3_BLT:  o_taken = i_aluLt;
      F3_BGE:  o_taken = !i_aluLt;
      F3_BLTU: o_taken = i_aluLtu;
      F3_BGEU: o_taken = !i_aluLtu;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32 core. Sequences fetch,
// decode, execute, memory and writeback, owns the memory handshake,
// and traps on illegal instructions or memory timeouts.
module multicycle_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TCNT_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic              i_aluZero,
  input  logic              i_aluLt,
  input  logic              i_aluLtu,
  multicycle_ctrl_if.master bus,
  output logic              o_irWrite,
  output logic              o_pcWrite,
  output logic              o_pcSrc,
  output logic              o_aluSrcB,
  output alu_op_t           o_aluOp,
  output logic              o_regWrite,
  output logic              o_memToReg,
  output logic              o_illegalInst,
  output logic              o_memFault,
  output logic              o_halted
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic              r_f7b5;
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_illegal;
  logic              r_fault;

  logic    w_taken;
  logic    w_brIllegal;
  logic    w_timeout;
  logic    w_waiting;
  logic    w_setIllegal;
  logic    w_setFault;
  logic    w_memReq;
  logic    w_memWe;
  logic    w_memAddrSel;
  logic    w_irWrite;
  logic    w_pcWrite;
  logic    w_pcSrc;
  logic    w_aluSrcB;
  alu_op_t w_aluOp;
  logic    w_regWrite;
  logic    w_memToReg;
  logic    w_halted;
  logic    w_unusedFunct7;

  // Only funct7[5] is meaningful to the ALU decode downstream.
  assign w_unusedFunct7 = ^{i_funct7[6], i_funct7[4:0], r_f7b5};

  branch_cond u_branchCond (
    .i_funct3  (r_funct3),
    .i_aluZero (i_aluZero),
    .i_aluLt   (i_aluLt),
    .i_aluLtu  (i_aluLtu),
    .o_taken   (w_taken),
    .o_illegal (w_brIllegal)
  );

  // The limit is hit on the last allowed waiting cycle; a same-cycle
  // memReady still completes the request.
  assign w_timeout = !bus.memReady && (r_tcnt == TCNT_LAST);

  // Next-state and Moore outputs; only fetch strobes follow memReady.
  always_comb begin
    w_next       = r_state;
    w_memReq     = 1'b0;
    w_memWe      = 1'b0;
    w_memAddrSel = 1'b0;
    w_irWrite    = 1'b0;
    w_pcWrite    = 1'b0;
    w_pcSrc      = 1'b0;
    w_aluSrcB    = 1'b0;
    w_aluOp      = ALU_ADD;
    w_regWrite   = 1'b0;
    w_memToReg   = 1'b0;
    w_halted     = 1'b0;
    w_waiting    = 1'b0;
    w_setIllegal = 1'b0;
    w_setFault   = 1'b0;
    case (r_state)
      FETCH: begin
        w_memReq  = 1'b1;
        w_waiting = !bus.memReady;
        if (bus.memReady) begin
          w_irWrite = 1'b1;
          w_pcWrite = 1'b1;
          w_next    = DECODE;
        end else if (w_timeout) begin
          w_setFault = 1'b1;
          w_next     = TRAP;
        end
      end
      DECODE: begin
        if (i_opcode == OP_RTYPE) begin
          w_next = EXEC_R;
        end else if (isMemOp(i_opcode)) begin
          w_next = ADDR_CALC;
        end else if (i_opcode == OP_BRANCH) begin
          w_next = BRANCH;
        end else begin
          w_setIllegal = 1'b1;
          w_next       = TRAP;
        end
      end
      EXEC_R: begin
        w_aluOp = ALU_FUNCT;
        w_next  = WB_R;
      end
      WB_R: begin
        w_regWrite = 1'b1;
        w_next     = FETCH;
      end
      ADDR_CALC: begin
        w_aluSrcB = 1'b1;
        w_next    = (r_opcode == OP_STORE) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        w_memReq     = 1'b1;
        w_memAddrSel = 1'b1;
        w_waiting    = !bus.memReady;
        if (bus.memReady) begin
          w_next = WB_LD;
        end else if (w_timeout) begin
          w_setFault = 1'b1;
          w_next     = TRAP;
        end
      end
      WB_LD: begin
        w_regWrite = 1'b1;
        w_memToReg = 1'b1;
        w_next     = FETCH;
      end
      MEM_WR: begin
        w_memReq     = 1'b1;
        w_memWe      = 1'b1;
        w_memAddrSel = 1'b1;
        w_waiting    = !bus.memReady;
        if (bus.memReady) begin
          w_next = FETCH;
        end else if (w_timeout) begin
          w_setFault = 1'b1;
          w_next     = TRAP;
        end
      end
      BRANCH: begin
        w_aluOp = ALU_CMP;
        w_pcSrc = 1'b1;
        if (w_brIllegal) begin
          w_setIllegal = 1'b1;
          w_next       = TRAP;
        end else begin
          w_pcWrite = w_taken;
          w_next    = FETCH;
        end
      end
      TRAP: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next = FETCH;
      end
    endcase
  end

  // State register; reset always restarts with a fresh fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the instruction fields seen during decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode <= '0;
      r_funct3 <= '0;
      r_f7b5   <= 1'b0;
    end else if (r_state == DECODE) begin
      r_opcode <= i_opcode;
      r_funct3 <= i_funct3;
      r_f7b5   <= i_funct7[5];
    end
  end

  // Wait counter restarts on every state change, so each memory state
  // begins its own timeout window.
  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state)) begin
      r_tcnt <= '0;
    end else if (w_waiting) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // Sticky trap causes, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      if (w_setIllegal) r_illegal <= 1'b1;
      if (w_setFault)   r_fault   <= 1'b1;
    end
  end

  assign bus.memReq     = w_memReq;
  assign bus.memWe      = w_memWe;
  assign bus.memAddrSel = w_memAddrSel;
  assign o_irWrite      = w_irWrite;
  assign o_pcWrite      = w_pcWrite;
  assign o_pcSrc        = w_pcSrc;
  assign o_aluSrcB      = w_aluSrcB;
  assign o_aluOp        = w_aluOp;
  assign o_regWrite     = w_regWrite;
  assign o_memToReg     = w_memToReg;
  assign o_illegalInst  = r_illegal;
  assign o_memFault     = r_fault;
  assign o_halted       = w_halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a memory responder with per-request
// latency, and an instruction-level model predicting how many cycles
// each instruction takes and how often each strobe fires.
module tb_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       aluZero, aluLt, aluLtu;
  logic       irWrite, pcWrite, pcSrc, aluSrcB;
  logic [1:0] aluOp;
  logic       regWrite, memToReg, illegalInst, memFault, halted;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TCNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_opcode      (opcode),
    .i_funct3      (funct3),
    .i_funct7      (funct7),
    .i_aluZero     (aluZero),
    .i_aluLt       (aluLt),
    .i_aluLtu      (aluLtu),
    .bus           (bus),
    .o_irWrite     (irWrite),
    .o_pcWrite     (pcWrite),
    .o_pcSrc       (pcSrc),
    .o_aluSrcB     (aluSrcB),
    .o_aluOp       (aluOp),
    .o_regWrite    (regWrite),
    .o_memToReg    (memToReg),
    .o_illegalInst (illegalInst),
    .o_memFault    (memFault),
    .o_halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles, irW, pcW, pcBr, regW, ldW, weCyc, reqCyc, functCyc, srcBCyc, haltCyc;
    bit trap, ill, fault;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   latFetch, latMem, waitCnt, curLat;
  logic prevReq, prevWe, prevSel;
  bit   justReset;
  exp_t obs;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic bit branchTaken(input logic [2:0] f3, input logic z, lt, ltu);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return ltu;
      default: return !ltu;
    endcase
  endfunction

  // Instruction-level expectations: cycles until the next fetch (or
  // until TRAP), and event counts over that window.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic z, lt, ltu, input int lf, lm);
    exp_t e;
    e = '{default: 0};
    if (lf >= MEM_TIMEOUT) begin
      e.cycles = MEM_TIMEOUT; e.reqCyc = MEM_TIMEOUT; e.trap = 1; e.fault = 1;
      return e;
    end
    e.cycles = lf + 2; e.reqCyc = lf + 1; e.irW = 1; e.pcW = 1;
    if (op == 7'b0110011) begin
      e.cycles += 2; e.functCyc = 1; e.regW = 1;
    end else if (op == 7'b0000011 || op == 7'b0100011) begin
      e.cycles += 1; e.srcBCyc = 1;
      if (lm >= MEM_TIMEOUT) begin
        e.cycles += MEM_TIMEOUT; e.reqCyc += MEM_TIMEOUT; e.trap = 1; e.fault = 1;
        if (op == 7'b0100011) e.weCyc = MEM_TIMEOUT;
      end else begin
        e.cycles += lm + 1; e.reqCyc += lm + 1;
        if (op == 7'b0100011) e.weCyc = lm + 1;
        else begin e.cycles += 1; e.regW = 1; e.ldW = 1; end
      end
    end else if (op == 7'b1100011) begin
      e.cycles += 1;
      if (f3 == 3'd2 || f3 == 3'd3) begin
        e.trap = 1; e.ill = 1;
      end else if (branchTaken(f3, z, lt, ltu)) begin
        e.pcW += 1; e.pcBr = 1;
      end
    end else begin
      e.trap = 1; e.ill = 1;
    end
    return e;
  endfunction

  // One clock: memory responder decides memReady, then outputs are sampled.
  task automatic cycleStep();
    @(negedge clk);
    if (bus.memReq) begin
      if (!prevReq || bus.memWe !== prevWe || bus.memAddrSel !== prevSel) begin
        waitCnt = 0;
        curLat  = bus.memAddrSel ? latMem : latFetch;
      end
      bus.memReady = (waitCnt == curLat);
      waitCnt++;
    end else begin
      bus.memReady = 1'b0;
    end
    prevReq = bus.memReq; prevWe = bus.memWe; prevSel = bus.memAddrSel;
    #1;
    if (irWrite) obs.irW++;
    if (pcWrite) obs.pcW++;
    if (pcWrite && pcSrc) obs.pcBr++;
    if (regWrite) obs.regW++;
    if (regWrite && memToReg) obs.ldW++;
    if (bus.memReq && bus.memWe) obs.weCyc++;
    if (bus.memReq) obs.reqCyc++;
    if (aluOp == 2'b10) obs.functCyc++;
    if (aluSrcB) obs.srcBCyc++;
    if (halted) obs.haltCyc++;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    bus.memReady = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    prevReq = 1'b0;
    checkOutput("rstMemReq", int'(bus.memReq), 1);
    checkOutput("rstAddrWe", int'({bus.memAddrSel, bus.memWe}), 0);
    checkOutput("rstHalted", int'(halted), 0);
    checkOutput("rstFlags", int'({illegalInst, memFault}), 0);
    checkOutput("rstStrobes", int'({irWrite, pcWrite, regWrite, aluSrcB, aluOp}), 0);
    justReset = 1'b1;
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic z, lt, ltu, input int lf, lm);
    exp_t e;
    e = model(op, f3, z, lt, ltu, lf, lm);
    if (!justReset) begin
      @(posedge clk);
      #1;
    end
    justReset = 1'b0;
    opcode = op; funct3 = f3; funct7 = 7'($urandom);
    aluZero = z; aluLt = lt; aluLtu = ltu;
    latFetch = lf; latMem = lm;
    obs = '{default: 0};
    for (int i = 0; i < e.cycles; i++) begin
      cycleStep();
      if (i == 0) checkOutput("startFetch", int'({bus.memReq, bus.memAddrSel, bus.memWe}), 4);
    end
    checkOutput("irWrite", obs.irW, e.irW);
    checkOutput("pcWrite", obs.pcW, e.pcW);
    checkOutput("pcBranch", obs.pcBr, e.pcBr);
    checkOutput("regWrite", obs.regW, e.regW);
    checkOutput("loadWb", obs.ldW, e.ldW);
    checkOutput("storeCycles", obs.weCyc, e.weCyc);
    checkOutput("reqCycles", obs.reqCyc, e.reqCyc);
    checkOutput("functCycles", obs.functCyc, e.functCyc);
    checkOutput("immCycles", obs.srcBCyc, e.srcBCyc);
    checkOutput("earlyHalt", obs.haltCyc, 0);
    if (e.trap) begin
      obs = '{default: 0};
      for (int i = 0; i < 20; i++) cycleStep();
      checkOutput("trapReq", obs.reqCyc, 0);
      checkOutput("trapHalted", obs.haltCyc, 20);
      checkOutput("trapStrobes", obs.irW + obs.pcW + obs.regW, 0);
      checkOutput("illegalInst", int'(illegalInst), int'(e.ill));
      checkOutput("memFault", int'(memFault), int'(e.fault));
      applyReset();
    end else begin
      checkOutput("flagsClear", int'({illegalInst, memFault}), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] op;
    int         pick, lm;
    rst = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0;
    aluZero = 0; aluLt = 0; aluLtu = 0;
    bus.memReady = 1'b0;
    prevReq = 0; prevWe = 0; prevSel = 0;
    waitCnt = 0; curLat = 0; latFetch = 0; latMem = 0;
    justReset = 1'b0;
    repeat (2) @(posedge clk);
    applyReset();

    applyStimulus(7'b0110011, 3'd0, 0, 0, 0, 0, 0);
    applyStimulus(7'b0000011, 3'd2, 0, 0, 0, 3, 2);
    applyStimulus(7'b0100011, 3'd2, 0, 0, 0, 1, 1);
    applyStimulus(7'b0100011, 3'd2, 0, 0, 0, 0, 0);
    applyStimulus(7'b1100011, 3'd0, 1, 0, 0, 0, 0);
    applyStimulus(7'b1100011, 3'd1, 1, 0, 0, 0, 0);
    applyStimulus(7'b1100011, 3'd7, 0, 1, 0, 1, 0);
    applyStimulus(7'b1100011, 3'd4, 0, 1, 0, 0, 0);
    applyStimulus(7'b0010011, 3'd0, 0, 0, 0, 0, 0);
    applyStimulus(7'b1100011, 3'd2, 1, 1, 1, 0, 0);
    applyStimulus(7'b0000011, 3'd2, 0, 0, 0, 0, 16);
    applyStimulus(7'b0000011, 3'd2, 0, 0, 0, 0, 15);
    applyStimulus(7'b0100011, 3'd2, 0, 0, 0, 2, 16);
    applyStimulus(7'b0110011, 3'd0, 0, 0, 0, 16, 0);

    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 19);
      if (pick < 6)       op = 7'b0110011;
      else if (pick < 10) op = 7'b0000011;
      else if (pick < 14) op = 7'b0100011;
      else if (pick < 19) op = 7'b1100011;
      else                op = 7'b0010011;
      lm = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      applyStimulus(op, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom_range(0, 3), lm);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
